// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side controller: output-stage state
// type and Gray/binary conversion helpers. Optional almost-empty flag is
// enabled with the FIFO_RD_ALMOST_EMPTY_EN macro (see fifo_rd_ctrl).
package fifo_pkg;

  // Output stage states: IDLE has no word held, HOLD presents a word.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } rd_state_t;

  // Working width of the conversion helpers; callers size-cast in and out.
  localparam int FN_W = 32;

  // Binary to reflected Gray code.
  function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Reflected Gray code back to binary (prefix XOR from the MSB down).
  function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] gray);
    logic [FN_W-1:0] bin;
    bin[FN_W-1] = gray[FN_W-1];
    for (int i = FN_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into the CLK domain.
// Only one bit changes per pointer step, so each stage sees a coherent value.
module ptr_sync #(
  parameter int WIDTH = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] async_ptr,
  output logic [WIDTH-1:0] sync_ptr
);

  logic [WIDTH-1:0] stage1_reg;
  logic [WIDTH-1:0] stage2_reg;

  // Two back-to-back capture stages; both clear on reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stage1_reg <= '0;
      stage2_reg <= '0;
    end else begin
      stage1_reg <= async_ptr;
      stage2_reg <= stage1_reg;
    end
  end

  assign sync_ptr = stage2_reg;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an asynchronous FIFO. Synchronizes the Gray write
// pointer, derives EMPTY, pops words from a combinational-read memory into a
// registered valid/ready output stage and returns its own Gray read pointer.
// Optional feature: define FIFO_RD_ALMOST_EMPTY_EN to add the registered
// ALMOST_EMPTY output (threshold AE_LEVEL words).
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4,
  parameter int AE_LEVEL      = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [ADDRESS_WIDTH:0] Wr_ptr_gray,
  input  logic [DATA_WIDTH-1:0]  Rd_DATA,
  output logic [ADDRESS_WIDTH-1:0] Rd_addr,
  output logic [ADDRESS_WIDTH:0] Rd_ptr_gray,
  output logic                   EMPTY,
  output logic [DATA_WIDTH-1:0]  Out_DATA,
  output logic                   Out_VALID,
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  output logic                   ALMOST_EMPTY,
`endif
  input  logic                   Out_READY
);

  // Pointers carry one extra MSB so full and empty wrap states differ.
  localparam int PW = ADDRESS_WIDTH + 1;

  logic [PW-1:0]         wq2;
  logic [PW-1:0]         rd_bin_reg;
  logic [PW-1:0]         rd_bin_next;
  logic [PW-1:0]         rd_gray_reg;
  logic [PW-1:0]         rd_gray_next;
  rd_state_t             state_reg;
  logic                  out_valid_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic                  empty;
  logic                  pop;

  ptr_sync #(
    .WIDTH(PW)
  ) u_wr_ptr_sync (
    .CLK      (CLK),
    .RST      (RST),
    .async_ptr(Wr_ptr_gray),
    .sync_ptr (wq2)
  );

  // Empty when our Gray pointer has caught up with the synchronized writer.
  assign empty = (rd_gray_reg == wq2);

  // A word is taken from memory whenever one exists and the output register
  // is free now or is being emptied by the consumer on this edge.
  assign pop = !empty && ((state_reg == IDLE) ||
                          ((state_reg == HOLD) && Out_READY));

  // Next pointer values; the Gray form is precomputed so it can be registered.
  always_comb begin
    rd_bin_next  = rd_bin_reg;
    if (pop) begin
      rd_bin_next = rd_bin_reg + PW'(1);
    end
    rd_gray_next = PW'(bin2gray(FN_W'(rd_bin_next)));
  end

  // Read pointer registers, binary for addressing and Gray for the writer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_bin_reg  <= '0;
      rd_gray_reg <= '0;
    end else begin
      rd_bin_reg  <= rd_bin_next;
      rd_gray_reg <= rd_gray_next;
    end
  end

  // Output stage: load on pop, drop to IDLE when the last held word is taken.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= IDLE;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pop) begin
            state_reg     <= HOLD;
            out_valid_reg <= 1'b1;
            out_data_reg  <= Rd_DATA;
          end
        end
        HOLD: begin
          if (Out_READY) begin
            if (pop) begin
              out_data_reg <= Rd_DATA;
            end else begin
              // Out_DATA deliberately keeps the last word when going idle.
              state_reg     <= IDLE;
              out_valid_reg <= 1'b0;
            end
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic [PW-1:0] wr_bin_sync;
  logic [PW-1:0] fill_next;
  logic          almost_empty_reg;

  // Fill level after this edge's pop, measured against the synchronized writer.
  assign wr_bin_sync = PW'(gray2bin(FN_W'(wq2)));
  assign fill_next   = wr_bin_sync - rd_bin_next;

  // Registered almost-empty flag; asserted from reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      almost_empty_reg <= 1'b1;
    end else begin
      almost_empty_reg <= (fill_next <= PW'(AE_LEVEL));
    end
  end

  assign ALMOST_EMPTY = almost_empty_reg;
`else
  // Almost-empty flag not built in this configuration.
`endif

  assign Rd_addr     = rd_bin_reg[ADDRESS_WIDTH-1:0];
  assign Rd_ptr_gray = rd_gray_reg;
  assign EMPTY       = empty;
  assign Out_DATA    = out_data_reg;
  assign Out_VALID   = out_valid_reg;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl (default parameters, depth 16).
// Define FIFO_RD_ALMOST_EMPTY_EN to also exercise ALMOST_EMPTY.
module tb_fifo_rd_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [4:0] Wr_ptr_gray = '0;
  logic [7:0] Rd_DATA;
  logic [3:0] Rd_addr;
  logic [4:0] Rd_ptr_gray;
  logic       EMPTY;
  logic [7:0] Out_DATA;
  logic       Out_VALID;
  logic       Out_READY = 1'b0;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic       ALMOST_EMPTY;
`endif

  int tests = 0;
  int fails = 0;

  // Write side as the bench sees it: memory, count of words written, and the
  // in-order list of words not yet handed to the output register.
  logic [7:0] mem [16];
  int         wr_count = 0;
  logic [7:0] pending_q [$];

  // Transaction-level reference: words visible to the reader lag the write
  // count by two clocks; the output holds at most one word.
  int         m_wq1 = 0;
  int         m_wq2 = 0;
  int         m_rd = 0;
  bit         m_valid = 0;
  logic [7:0] m_data = '0;
  bit         m_ae = 1;

  fifo_rd_ctrl #(
    .DATA_WIDTH   (8),
    .ADDRESS_WIDTH(4),
    .AE_LEVEL     (2)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .Wr_ptr_gray (Wr_ptr_gray),
    .Rd_DATA     (Rd_DATA),
    .Rd_addr     (Rd_addr),
    .Rd_ptr_gray (Rd_ptr_gray),
    .EMPTY       (EMPTY),
    .Out_DATA    (Out_DATA),
    .Out_VALID   (Out_VALID),
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    .ALMOST_EMPTY(ALMOST_EMPTY),
`endif
    .Out_READY   (Out_READY)
  );

  always #5 CLK = ~CLK;

  assign Rd_DATA = mem[Rd_addr];

  function automatic logic [4:0] gray(input int n);
    logic [4:0] b;
    b = 5'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic wr_word(input logic [7:0] d);
    mem[wr_count % 16] = d;
    pending_q.push_back(d);
    wr_count++;
    Wr_ptr_gray = gray(wr_count);
  endtask

  // One clock: advance the reference on the edge, then settle past it.
  task automatic step();
    int  old_wq2;
    bit  do_pop;
    @(posedge CLK);
    if (RST) begin
      m_wq1 = 0; m_wq2 = 0; m_rd = 0;
      m_valid = 0; m_data = '0; m_ae = 1;
    end else begin
      old_wq2 = m_wq2;
      do_pop = (m_wq2 - m_rd > 0) && (!m_valid || Out_READY);
      if (do_pop) begin
        m_data  = pending_q.pop_front();
        m_rd++;
        m_valid = 1;
      end else if (m_valid && Out_READY) begin
        m_valid = 0;
      end
      m_ae  = (old_wq2 - m_rd) <= 2;
      m_wq2 = m_wq1;
      m_wq1 = wr_count;
    end
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    Out_READY = 1'b0;
    wr_count = 0;
    Wr_ptr_gray = '0;
    pending_q.delete();
    repeat (2) step();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) step();
    tests++; if (Out_VALID !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", Out_VALID); end
    tests++; if (EMPTY !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b expected 1", EMPTY); end
    tests++; if (Rd_ptr_gray !== 5'd0) begin fails++; $display("FAIL reset_rdgray: got %b expected 00000", Rd_ptr_gray); end
    tests++; if (Rd_addr !== 4'd0) begin fails++; $display("FAIL reset_rdaddr: got %0d expected 0", Rd_addr); end
    tests++; if (Out_DATA !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", Out_DATA); end
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    tests++; if (ALMOST_EMPTY !== 1'b1) begin fails++; $display("FAIL reset_ae: got %b expected 1", ALMOST_EMPTY); end
`endif
    RST = 1'b0;
    $display("[TB] reset: valid=%b empty=%b rd_gray=%b", Out_VALID, EMPTY, Rd_ptr_gray);
  endtask

  // One word A5: EMPTY falls after two edges, Out_VALID rises on the third.
  task automatic test_single_word();
    Out_READY = 1'b0;
    wr_word(8'hA5);
    step();
    tests++; if (Out_VALID !== 1'b0 || EMPTY !== 1'b1) begin fails++; $display("FAIL single_edge1: got valid=%b empty=%b expected 0/1", Out_VALID, EMPTY); end
    step();
    tests++; if (Out_VALID !== 1'b0 || EMPTY !== 1'b0) begin fails++; $display("FAIL single_edge2: got valid=%b empty=%b expected 0/0", Out_VALID, EMPTY); end
    step();
    tests++; if (Out_VALID !== 1'b1) begin fails++; $display("FAIL single_valid: got %b expected 1", Out_VALID); end
    tests++; if (Out_DATA !== 8'hA5) begin fails++; $display("FAIL single_data: got %h expected a5", Out_DATA); end
    tests++; if (Rd_ptr_gray !== 5'b00001) begin fails++; $display("FAIL single_rdgray: got %b expected 00001", Rd_ptr_gray); end
    tests++; if (EMPTY !== 1'b1) begin fails++; $display("FAIL single_empty: got %b expected 1", EMPTY); end
    $display("[TB] single word: valid=%b data=%h rd_gray=%b", Out_VALID, Out_DATA, Rd_ptr_gray);
  endtask

  // Asynchronous reset while a word is held takes effect before any edge.
  task automatic test_reset_mid_hold();
    #2;
    RST = 1'b1;
    #1;
    tests++; if (Out_VALID !== 1'b0) begin fails++; $display("FAIL async_rst_valid: got %b expected 0", Out_VALID); end
    tests++; if (EMPTY !== 1'b1) begin fails++; $display("FAIL async_rst_empty: got %b expected 1", EMPTY); end
    tests++; if (Rd_ptr_gray !== 5'd0 || Rd_addr !== 4'd0) begin fails++; $display("FAIL async_rst_ptr: got gray=%b addr=%0d expected 0/0", Rd_ptr_gray, Rd_addr); end
    do_reset();
    step();
    tests++; if (Out_VALID !== 1'b0) begin fails++; $display("FAIL post_rst_valid: got %b expected 0", Out_VALID); end
    $display("[TB] reset mid-hold: valid=%b empty=%b", Out_VALID, EMPTY);
  endtask

  task automatic test_backpressure();
    do_reset();
    Out_READY = 1'b0;
    wr_word(8'h11); wr_word(8'h22); wr_word(8'h33);
    repeat (3) step();
    for (int i = 0; i < 5; i++) begin
      step();
      tests++; if (Out_VALID !== 1'b1 || Out_DATA !== 8'h11 || Rd_addr !== 4'd1) begin
        fails++; $display("FAIL bp_hold%0d: got valid=%b data=%h addr=%0d expected 1/11/1", i, Out_VALID, Out_DATA, Rd_addr);
      end
    end
    Out_READY = 1'b1;
    step();
    tests++; if (Out_VALID !== 1'b1 || Out_DATA !== 8'h22) begin fails++; $display("FAIL bp_word2: got valid=%b data=%h expected 1/22", Out_VALID, Out_DATA); end
    step();
    tests++; if (Out_VALID !== 1'b1 || Out_DATA !== 8'h33) begin fails++; $display("FAIL bp_word3: got valid=%b data=%h expected 1/33", Out_VALID, Out_DATA); end
    step();
    tests++; if (Out_VALID !== 1'b0 || Out_DATA !== 8'h33 || EMPTY !== 1'b1) begin
      fails++; $display("FAIL bp_idle: got valid=%b data=%h empty=%b expected 0/33/1", Out_VALID, Out_DATA, EMPTY);
    end
    $display("[TB] backpressure: final valid=%b data=%h", Out_VALID, Out_DATA);
  endtask

  // 20 words through a depth-16 memory: Gray sequence, address wrap, order.
  task automatic test_wrap();
    logic [7:0] words [20];
    logic [4:0] prev_gray;
    int         n = 0;
    do_reset();
    Out_READY = 1'b1;
    for (int i = 0; i < 20; i++) words[i] = 8'($urandom);
    prev_gray = Rd_ptr_gray;
    for (int cyc = 0; cyc < 80 && n < 20; cyc++) begin
      if (wr_count < 20 && (wr_count - m_rd) < 16) wr_word(words[wr_count]);
      step();
      if (Rd_ptr_gray !== prev_gray) begin
        n++;
        tests++; if (Rd_ptr_gray !== gray(n) || Rd_addr !== 4'(n % 16) || Out_DATA !== words[n-1]) begin
          fails++; $display("FAIL wrap_word%0d: got gray=%b addr=%0d data=%h expected %b/%0d/%h",
                            n, Rd_ptr_gray, Rd_addr, Out_DATA, gray(n), n % 16, words[n-1]);
        end
        prev_gray = Rd_ptr_gray;
      end
    end
    tests++; if (n != 20) begin fails++; $display("FAIL wrap_count: got %0d words expected 20", n); end
    $display("[TB] wrap: %0d words, final rd_gray=%b addr=%0d", n, Rd_ptr_gray, Rd_addr);
  endtask

  // Last word consumed on the same edge a new write pointer is captured.
  task automatic test_simultaneous();
    do_reset();
    Out_READY = 1'b1;
    wr_word(8'h5C);
    repeat (3) step();
    tests++; if (Out_VALID !== 1'b1 || Out_DATA !== 8'h5C) begin fails++; $display("FAIL sim_first: got valid=%b data=%h expected 1/5c", Out_VALID, Out_DATA); end
    wr_word(8'hC3);
    step();
    tests++; if (Out_VALID !== 1'b0) begin fails++; $display("FAIL sim_idle1: got %b expected 0", Out_VALID); end
    step();
    tests++; if (Out_VALID !== 1'b0) begin fails++; $display("FAIL sim_idle2: got %b expected 0", Out_VALID); end
    step();
    tests++; if (Out_VALID !== 1'b1 || Out_DATA !== 8'hC3 || Rd_ptr_gray !== 5'b00011) begin
      fails++; $display("FAIL sim_second: got valid=%b data=%h gray=%b expected 1/c3/00011", Out_VALID, Out_DATA, Rd_ptr_gray);
    end
    step();
    tests++; if (Out_VALID !== 1'b0 || Rd_ptr_gray !== 5'b00011) begin
      fails++; $display("FAIL sim_nodup: got valid=%b gray=%b expected 0/00011", Out_VALID, Rd_ptr_gray);
    end
    $display("[TB] simultaneous: valid=%b data=%h", Out_VALID, Out_DATA);
  endtask

`ifdef FIFO_RD_ALMOST_EMPTY_EN
  task automatic test_almost_empty();
    do_reset();
    Out_READY = 1'b0;
    for (int i = 0; i < 5; i++) wr_word(8'(8'h60 + i));
    repeat (3) step();
    tests++; if (ALMOST_EMPTY !== 1'b0) begin fails++; $display("FAIL ae_four_pending: got %b expected 0", ALMOST_EMPTY); end
    Out_READY = 1'b1;
    step();
    tests++; if (ALMOST_EMPTY !== 1'b0) begin fails++; $display("FAIL ae_one_pop: got %b expected 0", ALMOST_EMPTY); end
    step();
    tests++; if (ALMOST_EMPTY !== 1'b1) begin fails++; $display("FAIL ae_two_pops: got %b expected 1", ALMOST_EMPTY); end
    repeat (4) step();
    $display("[TB] almost empty: ae=%b", ALMOST_EMPTY);
  endtask
`endif

  // Random writes and backpressure checked cycle by cycle against the model.
  task automatic test_random();
    int accepted = 0;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if ((wr_count - m_rd) < 16 && $urandom_range(0, 2) != 0) wr_word(8'($urandom));
      Out_READY = ($urandom_range(0, 3) != 0);
      if (Out_VALID && Out_READY) accepted++;
      step();
      tests++; if (Out_VALID !== m_valid || Out_DATA !== m_data || EMPTY !== (m_wq2 == m_rd)) begin
        fails++; $display("FAIL rand_out cyc%0d: got valid=%b data=%h empty=%b expected %b/%h/%b",
                          cyc, Out_VALID, Out_DATA, EMPTY, m_valid, m_data, (m_wq2 == m_rd));
      end
      tests++; if (Rd_ptr_gray !== gray(m_rd) || Rd_addr !== 4'(m_rd % 16)) begin
        fails++; $display("FAIL rand_ptr cyc%0d: got gray=%b addr=%0d expected %b/%0d",
                          cyc, Rd_ptr_gray, Rd_addr, gray(m_rd), m_rd % 16);
      end
`ifdef FIFO_RD_ALMOST_EMPTY_EN
      tests++; if (ALMOST_EMPTY !== m_ae) begin fails++; $display("FAIL rand_ae cyc%0d: got %b expected %b", cyc, ALMOST_EMPTY, m_ae); end
`endif
    end
    Out_READY = 1'b1;
    repeat (24) step();
    tests++; if (Out_VALID !== 1'b0 || EMPTY !== 1'b1 || Rd_ptr_gray !== gray(wr_count)) begin
      fails++; $display("FAIL rand_drain: got valid=%b empty=%b gray=%b expected 0/1/%b", Out_VALID, EMPTY, Rd_ptr_gray, gray(wr_count));
    end
    $display("[TB] random: %0d words written, %0d accepted before drain", wr_count, accepted);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_reset_mid_hold();
    test_backpressure();
    test_wrap();
    test_simultaneous();
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    test_almost_empty();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 4, memory address width; depth = 2**ADDRESS_WIDTH.
REQ-003 SHALL have parameter AE_LEVEL, default 2, almost-empty threshold in words (used only under FIFO_RD_ALMOST_EMPTY_EN).
REQ-004 Port CLK  in  1  sole clock, rising edge.
REQ-005 Port RST  in  1  reset, asynchronous, active-high.
REQ-006 Port Wr_ptr_gray  in  ADDRESS_WIDTH+1  write pointer, Gray-coded, from the write-clock domain.
REQ-007 Port Rd_DATA  in  DATA_WIDTH  combinational memory read data at Rd_addr.
REQ-008 Port Rd_addr  out  ADDRESS_WIDTH  memory read address = low bits of binary read pointer.
REQ-009 Port Rd_ptr_gray  out  ADDRESS_WIDTH+1  registered Gray read pointer, sent to write domain.
REQ-010 Port EMPTY  out  1  no unread word in memory.
REQ-011 Port Out_DATA  out  DATA_WIDTH  registered output word.
REQ-012 Port Out_VALID  out  1  Out_DATA holds a word.
REQ-013 Port Out_READY  in  1  consumer accepts Out_DATA this cycle.
REQ-014 Port ALMOST_EMPTY  out  1  present only under FIFO_RD_ALMOST_EMPTY_EN.

Function
REQ-015 Wr_ptr_gray SHALL pass through a 2-flop synchronizer (wq2) before any use.
REQ-016 EMPTY SHALL equal (Rd_ptr_gray == wq2), combinational from registers.
REQ-017 Output stage SHALL be a 2-state FSM: IDLE (Out_VALID=0), HOLD (Out_VALID=1).
REQ-018 Pop SHALL occur when !EMPTY and (IDLE, or HOLD with Out_READY=1).
REQ-019 On pop: Out_DATA <= Rd_DATA, binary pointer +1, Rd_ptr_gray <= gray(pointer+1), FSM -> HOLD, all at the same edge.
REQ-020 HOLD with Out_READY=1 and EMPTY=1 SHALL go IDLE; Out_DATA retains last value.
REQ-021 HOLD with Out_READY=0 SHALL keep Out_DATA, Out_VALID and pointer unchanged.
REQ-022 Out_READY SHALL be ignored in IDLE.
REQ-023 Pointer SHALL wrap modulo 2**(ADDRESS_WIDTH+1); MSB toggles on each address wrap.
REQ-024 Latency: Wr_ptr_gray change captured at edge N -> EMPTY low after N+2 -> Out_VALID high after N+3.
REQ-025 Back-to-back: with Out_READY held 1 and data available, one word per cycle.

Reset
REQ-026 RST high SHALL asynchronously clear: binary pointer, Rd_ptr_gray, Rd_addr, wq2 stages, Out_DATA to 0; FSM to IDLE; Out_VALID 0; EMPTY 1; ALMOST_EMPTY 1.
REQ-027 RST mid-transfer SHALL discard the held word; no pop on the releasing edge unless EMPTY=0 by then.

Configuration
REQ-028 With FIFO_RD_ALMOST_EMPTY_EN defined: ALMOST_EMPTY registered, 1 when (bin(wq2) - read pointer) mod 2**(ADDRESS_WIDTH+1) <= AE_LEVEL.
REQ-029 Without FIFO_RD_ALMOST_EMPTY_EN: ALMOST_EMPTY port, its logic and AE_LEVEL usage absent; all other behaviour identical.

Structure
REQ-030 Package fifo_pkg SHALL hold bin2gray/gray2bin functions and the FSM state typedef (IDLE, HOLD).
REQ-031 Synchronizer SHALL be sub-module ptr_sync (2-flop, parameterized width, CLK/RST as here).

Verification
REQ-032 Reset: assert RST mid-HOLD -> immediately Out_VALID=0, EMPTY=1, Rd_ptr_gray=0, Rd_addr=0.
REQ-033 Single word: Wr_ptr_gray 00000->00001, Rd_DATA=0xA5 -> Out_VALID=1, Out_DATA=0xA5 3 edges later, Rd_ptr_gray=00001, EMPTY=1.
REQ-034 Backpressure: 3 words 0x11,0x22,0x33 available, Out_READY=0 for 5 cycles -> Out_DATA stays 0x11, Rd_addr stays 1; Out_READY=1 -> 0x22, 0x33 on consecutive cycles, then IDLE.
REQ-035 Wrap: 20 words written/read at depth 16 -> Rd_ptr_gray sequence matches gray(0..20), Rd_addr wraps 15->0, data order preserved.
REQ-036 Almost-empty (macro on, AE_LEVEL=2): 4 words pending -> ALMOST_EMPTY=0; after 2 pops -> 1.
REQ-037 Simultaneous: last word consumed (Out_READY=1) same edge a new Wr_ptr_gray arrives -> IDLE for 2 cycles, then new word valid, no loss or duplicate.
